// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-approach traffic light sequencer with all-red clearance and latched pedestrian walk.
// Define NIGHT_FLASH_EN to add the flash input and the flashing night mode.
module intersection_ctrl #(
  parameter int GREEN_TICKS  = 60,
  parameter int YELLOW_TICKS = 6,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       veh_b,
  input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       flash,
`endif
  output logic [2:0] leds_a,
  output logic [2:0] leds_b,
  output logic       ped_walk,
  output logic [2:0] phase
);
  localparam int M1 = GREEN_TICKS > YELLOW_TICKS ? GREEN_TICKS : YELLOW_TICKS;
  localparam int M2 = ALLRED_TICKS > WALK_TICKS ? ALLRED_TICKS : WALK_TICKS;
  localparam int CW = $clog2(M1 > M2 ? M1 : M2) + 1;
  typedef enum logic [2:0] {IDLE, A_GRN, A_YEL, RED1, B_GRN, B_YEL, RED2, WALK} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic ped_pending, ret_b, enter_walk;
  logic [2:0] la, lb;
`ifdef NIGHT_FLASH_EN
  logic flash_on;
`endif
  assign phase = state;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:  nxt = A_GRN;
      A_GRN: nxt = (cnt >= CW'(GREEN_TICKS - 1) && (veh_b | ped_pending)) ? A_YEL : A_GRN;
      A_YEL: nxt = cnt == CW'(YELLOW_TICKS - 1) ? RED1 : A_YEL;
      RED1:  nxt = cnt == CW'(ALLRED_TICKS - 1) ? (ped_pending ? WALK : B_GRN) : RED1;
      B_GRN: nxt = cnt == CW'(GREEN_TICKS - 1) ? B_YEL : B_GRN;
      B_YEL: nxt = cnt == CW'(YELLOW_TICKS - 1) ? RED2 : B_YEL;
      RED2:  nxt = cnt == CW'(ALLRED_TICKS - 1) ? (ped_pending ? WALK : A_GRN) : RED2;
      WALK:  nxt = cnt == CW'(WALK_TICKS - 1) ? (ret_b ? B_GRN : A_GRN) : WALK;
      default: nxt = IDLE;
    endcase
    enter_walk = nxt == WALK && state != WALK;
    la = nxt == A_GRN ? 3'b100 : nxt == A_YEL ? 3'b010 : nxt == IDLE ? 3'b000 : 3'b001;
    lb = nxt == B_GRN ? 3'b100 : nxt == B_YEL ? 3'b010 : nxt == IDLE ? 3'b000 : 3'b001;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ped_pending <= 1'b0;
      ret_b       <= 1'b0;
      leds_a      <= 3'b000;
      leds_b      <= 3'b000;
      ped_walk    <= 1'b0;
`ifdef NIGHT_FLASH_EN
      flash_on    <= 1'b0;
`endif
    end
`ifdef NIGHT_FLASH_EN
    else if (flash) begin
      state    <= IDLE;
      cnt      <= '0;
      flash_on <= 1'b1;
      ped_walk <= 1'b0;
      leds_a   <= flash_on ? leds_a ^ 3'b010 : 3'b010;
      leds_b   <= flash_on ? leds_b ^ 3'b001 : 3'b001;
    end else if (flash_on) begin
      flash_on    <= 1'b0;
      state       <= RED2;
      cnt         <= '0;
      ped_pending <= ped_pending | ped_req;
      leds_a      <= 3'b001;
      leds_b      <= 3'b001;
      ped_walk    <= 1'b0;
    end
`endif
    else begin
      state       <= nxt;
      cnt         <= nxt != state ? '0 : (&cnt ? cnt : cnt + 1'b1);
      ped_pending <= enter_walk ? 1'b0 : ped_pending | ped_req;
      if (enter_walk) ret_b <= state == RED1;
      leds_a      <= la;
      leds_b      <= lb;
      ped_walk    <= nxt == WALK;
    end
  end
endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: scoreboard bench for intersection_ctrl; expected light patterns are queued per phase and compared at negedge.
module tb_intersection_ctrl;
  logic clk = 1'b0, rst = 1'b1, veh_b = 1'b1, ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
  logic flash = 1'b0;
`endif
  logic [2:0] leds_a, leds_b, phase;
  logic ped_walk;
  int checks = 0, errors = 0;
  logic [9:0] sb[$];
  localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001, O = 3'b000;
  always #5 clk = ~clk;
  intersection_ctrl dut (
    .clk(clk), .rst(rst), .veh_b(veh_b), .ped_req(ped_req),
`ifdef NIGHT_FLASH_EN
    .flash(flash),
`endif
    .leds_a(leds_a), .leds_b(leds_b), .ped_walk(ped_walk), .phase(phase)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", tag, $time, obs, exp);
    end
  endtask
  task automatic push(input logic [2:0] a, input logic [2:0] b, input logic w, input logic [2:0] ph, input int n);
    repeat (n) sb.push_back({a, b, w, ph});
  endtask
  task automatic drain(input int n);
    logic [9:0] e;
    repeat (n) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("lights", {leds_a, leds_b, ped_walk, phase}, e);
        chk("safety", (|leds_a[2:1]) & (|leds_b[2:1]), 0);
      end
    end
  endtask
  task automatic seg(input logic [2:0] ph, input int n);
    case (ph)
      3'd1: push(G, R, 1'b0, ph, n);
      3'd2: push(Y, R, 1'b0, ph, n);
      3'd4: push(R, G, 1'b0, ph, n);
      3'd5: push(R, Y, 1'b0, ph, n);
      3'd7: push(R, R, 1'b1, ph, n);
      3'd0: push(O, O, 1'b0, ph, n);
      default: push(R, R, 1'b0, ph, n);
    endcase
    drain(n);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    #2 rst = 1'b0;
    #1 chk("rst_async", {leds_a, leds_b, ped_walk, phase}, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold", {leds_a, leds_b, ped_walk, phase}, 0);
    rst = 1'b1;
    seg(1, 60); seg(2, 6); seg(3, 2); seg(4, 60); seg(5, 6); seg(6, 2); seg(1, 1);
    veh_b = 1'b0;
    seg(1, 199);
    veh_b = 1'b1;
    seg(2, 6); seg(3, 2);
    seg(4, 10);
    ped_req = 1'b1; seg(4, 1); ped_req = 1'b0;
    seg(4, 49); seg(5, 6); seg(6, 2); seg(7, 10); seg(1, 60); seg(2, 6); seg(3, 2);
    seg(4, 5);
    ped_req = 1'b1; seg(4, 1); ped_req = 1'b0;
    seg(4, 54); seg(5, 6); seg(6, 2);
    ped_req = 1'b1; seg(7, 1); ped_req = 1'b0;
    seg(7, 9); seg(1, 60); seg(2, 6); seg(3, 2); seg(4, 60);
    seg(5, 2);
    ped_req = 1'b1; seg(5, 1); ped_req = 1'b0;
    #1 rst = 1'b0;
    #1 chk("rst_mid_yel", {leds_a, leds_b, ped_walk, phase}, 0);
    @(negedge clk);
    chk("rst_mid_hold", {leds_a, leds_b, ped_walk, phase}, 0);
    rst = 1'b1;
    seg(1, 60); seg(2, 6); seg(3, 2); seg(4, 1);
`ifdef NIGHT_FLASH_EN
    flash = 1'b1;
    for (int i = 0; i < 8; i++) push(i % 2 ? O : Y, i % 2 ? O : R, 1'b0, 3'd0, 1);
    drain(8);
    flash = 1'b0;
    seg(6, 2); seg(1, 5);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
